wb_arbiter: RTL

Parametrised writeback arbiter for the memory/writeback stage. It decodes the MW-latch instruction into a register-file write: destination, data, enable, and exception/rstatus redirection. It also buffers results from the multicycle mult/div unit in a small in-order queue and retires them into free writeback slots. Anti-starvation logic requests a one-cycle pipeline freeze when queued results cannot drain.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/wb_queue.sv | 73 +++++++
 rtl/wb_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants, writeback register defaults and the queue entry type
package cpu_pkg;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam int STATUS_REG_DEF = 30;
  localparam int LINK_REG_DEF   = 31;
  localparam int DATA_W_DEF     = 32;
  localparam int RA_W_DEF       = 5;
  typedef struct packed {
    logic [RA_W_DEF-1:0]   rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_queue.sv
// wb_queue: in-order mult/div result buffer with squash-by-rd
// Ports: push_i/push_rd_i/push_data_i enqueue, pop_i retires head, squash_i/squash_rd_i
// invalidate matching entries, head_*_o expose the oldest entry, count_o/ready_o report occupancy.
module wb_queue #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int DEPTH  = 2,
  parameter int CW     = $clog2(DEPTH+1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic [RA_W-1:0]   push_rd_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              squash_i,
  input  logic [RA_W-1:0]   squash_rd_i,
  output logic              head_valid_o,
  output logic [RA_W-1:0]   head_rd_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [CW-1:0]     count_o,
  output logic              ready_o
);
  logic [RA_W-1:0]   rd_q [DEPTH];
  logic [RA_W-1:0]   rd_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  val_q, val_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ready_q;
  // Survivors are packed toward slot 0 so the head is always slot 0 and
  // squashed holes give their space back in the same edge.
  always_comb begin
    int k;
    rd_d   = rd_q;
    data_d = data_q;
    val_d  = '0;
    k      = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (val_q[i] && !(pop_i && i == 0) && !(squash_i && rd_q[i] == squash_rd_i)) begin
        rd_d[k]   = rd_q[i];
        data_d[k] = data_q[i];
        val_d[k]  = 1'b1;
        k++;
      end
    end
    if (push_i && !(squash_i && push_rd_i == squash_rd_i) && k < DEPTH) begin
      rd_d[k]   = push_rd_i;
      data_d[k] = push_data_i;
      val_d[k]  = 1'b1;
      k++;
    end
    count_d = CW'(k);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      val_q   <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
    end else begin
      val_q   <= val_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      count_q <= count_d;
      ready_q <= count_d < CW'(DEPTH);
    end
  end
  assign head_valid_o = val_q[0];
  assign head_rd_o    = rd_q[0];
  assign head_data_o  = data_q[0];
  assign count_o      = count_q;
  assign ready_o      = ready_q;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback decode plus arbitration between the pipeline and queued mult/div results
// Ports: clock/reset; ir, wb_data, exception from the MW latch; md_* mult/div offer;
// rf_we/rf_rd/rf_data register-file write; mem_sel lw select; stall_req freeze; pend_count occupancy.
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int RA_W       = 5,
  parameter int DEPTH      = 2,
  parameter int STATUS_REG = STATUS_REG_DEF,
  parameter int LINK_REG   = LINK_REG_DEF,
  parameter int STARVE_MAX = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [31:0]                ir,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic [2:0]                 exception,
  input  logic                       md_valid,
  input  logic [RA_W-1:0]            md_rd,
  input  logic [DATA_W-1:0]          md_data,
  input  logic                       md_excep,
  input  logic [2:0]                 md_status,
  output logic                       md_ready,
  output logic                       mem_sel,
  output logic                       rf_we,
  output logic [RA_W-1:0]            rf_rd,
  output logic [DATA_W-1:0]          rf_data,
  output logic                       stall_req,
  output logic [$clog2(DEPTH+1)-1:0] pend_count
);
  localparam int SW = $clog2(STARVE_MAX+1);
  logic [4:0]        op;
  logic              no_wr, has_exc, p_we;
  logic [RA_W-1:0]   p_rd, md_rd_e, head_rd;
  logic [DATA_W-1:0] p_data, md_data_e, head_data;
  logic              head_v, retire, bypass, push, blocked;
  logic              stall_q, stall_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              unused_ir;
  assign unused_ir = ^ir[21:0];
  assign op      = ir[31:27];
  assign has_exc = exception != 3'd0;
  assign no_wr   = ir == 32'd0 || op inside {OP_J, OP_BNE, OP_JR, OP_BLT, OP_SW};
  // A pending exception records itself in rstatus regardless of the opcode.
  assign p_rd    = has_exc ? RA_W'(STATUS_REG) : op == OP_SETX ? RA_W'(STATUS_REG) :
                   op == OP_JAL ? RA_W'(LINK_REG) : RA_W'(ir[26:22]);
  assign p_data  = has_exc ? DATA_W'(exception) : wb_data;
  assign p_we    = (has_exc || !no_wr) && p_rd != '0 && !stall_q;
  assign mem_sel = op == OP_LW;
  assign md_rd_e   = md_excep ? RA_W'(STATUS_REG) : md_rd;
  assign md_data_e = md_excep ? DATA_W'(md_status) : md_data;
  assign retire = !p_we && head_v;
  assign bypass = !p_we && !head_v && md_valid && md_rd_e != '0;
  assign push   = md_valid && md_ready && md_rd_e != '0 && !bypass;
  assign rf_we   = p_we || retire || bypass;
  assign rf_rd   = p_we ? p_rd : retire ? head_rd : md_rd_e;
  assign rf_data = p_we ? p_data : retire ? head_data : md_data_e;
  wb_queue #(.DATA_W(DATA_W), .RA_W(RA_W), .DEPTH(DEPTH)) u_queue (
    .clock(clock),
    .reset(reset),
    .push_i(push),
    .push_rd_i(md_rd_e),
    .push_data_i(md_data_e),
    .pop_i(retire),
    .squash_i(p_we),
    .squash_rd_i(p_rd),
    .head_valid_o(head_v),
    .head_rd_o(head_rd),
    .head_data_o(head_data),
    .count_o(pend_count),
    .ready_o(md_ready)
  );
  assign blocked  = head_v && !retire;
  assign stall_d  = blocked && starve_q == SW'(STARVE_MAX-1);
  assign starve_d = (blocked && !stall_d) ? starve_q + 1'b1 : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q  <= 1'b0;
      starve_q <= '0;
    end else begin
      stall_q  <= stall_d;
      starve_q <= starve_d;
    end
  end
  assign stall_req = stall_q;
endmodule
